// File: rtl/pdp8ltty_uart.sv
// pdp8ltty_uart -- hardware serial console bridge for the PDP-8/L teletype.
//
// Acts as bus master on the teletype's ARM register port. Characters the
// PDP-8/L prints (reg 2, prfull) are shifted out as 8N1 on txd and then
// acknowledged with a reg 2 write (prflag=1, prfull=0). Bytes received on
// rxd are written into the keyboard register (reg 1) with kbflag set.
//
// Ports:
//   CLOCK, RESET        clock, asynchronous active-low reset
//   enable              bridge enable (gates new prints and keyboard writes)
//   rxd / txd           serial receive / transmit lines, both idle high
//   armwrite            one-cycle write strobe to the teletype
//   armraddr            read address: 1 during a keyboard write, else 2
//   armwaddr, armwdata  write address / data for armwrite
//   armrdata            teletype read data, combinational from armraddr
//   kbovrun, frmerr     sticky overrun / framing error flags
//   clrerr              synchronous clear of the sticky flags
module pdp8ltty_uart #(
   parameter int CLKDIV  = 868,
   parameter int MARKPAR = 1
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        enable,
   input  logic        rxd,
   output logic        txd,
   output logic        armwrite,
   output logic [1:0]  armraddr,
   output logic [1:0]  armwaddr,
   output logic [31:0] armwdata,
   input  logic [31:0] armrdata,
   output logic        kbovrun,
   output logic        frmerr,
   input  logic        clrerr
);

   localparam logic [15:0] BIT_LAST  = 16'(CLKDIV - 1);
   // Loaded on the edge that leaves RX_IDLE, which is one cycle after the
   // falling edge appears at rx_sync; the start sample then lands exactly
   // CLKDIV/2 cycles after that edge.
   localparam logic [15:0] HALF_LOAD = 16'(CLKDIV / 2 - 2);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_DONE, TX_GAP}   tx_state_t;

   rx_state_t   rx_state, rx_next;
   logic        rx_meta, rx_sync, rx_prev;
   logic [15:0] rx_cnt;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_shift, rxbuf;
   logic        rxpend, rx_tick, rx_fall, rx_done, rx_ferr;

   tx_state_t   tx_state, tx_next;
   logic [15:0] tx_cnt;
   logic [3:0]  tx_bit;
   logic [7:0]  tx_shift;
   logic        tx_tick, tx_start, pr_wr, kb_wr;

   logic        unused_rdata;
   assign unused_rdata = ^armrdata[29:8];

   assign rx_tick = (rx_cnt == 16'd0);
   assign rx_fall = rx_prev & ~rx_sync;
   assign tx_tick = (tx_cnt == 16'd0);
   // A pending byte is consumed every cycle; with enable low it is simply lost.
   assign kb_wr   = rxpend & enable;

   // ---------------- receiver ----------------
   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      rx_next = rx_state;
      rx_done = 1'b0;
      rx_ferr = 1'b0;
      unique case (rx_state)
         RX_IDLE:  if (rx_fall) rx_next = RX_START;
         RX_START: if (rx_tick) rx_next = rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
         RX_STOP:  if (rx_tick) begin
                      rx_next = RX_IDLE;
                      rx_done = rx_sync;
                      rx_ferr = ~rx_sync;
                   end
         default:  rx_next = RX_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its inputs from before the edge, independent of statement order.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         rx_state <= RX_IDLE;
      end else begin
         rx_state <= rx_next;
      end
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         rx_meta  <= 1'b1;
         rx_sync  <= 1'b1;
         rx_prev  <= 1'b1;
         rx_cnt   <= 16'd0;
         rx_bit   <= 3'd0;
         rx_shift <= 8'd0;
         rxbuf    <= 8'd0;
         rxpend   <= 1'b0;
      end else begin
         rx_meta <= rxd;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
         if (rx_state == RX_IDLE) begin
            rx_cnt <= HALF_LOAD;
            rx_bit <= 3'd0;
         end else if (rx_tick) begin
            rx_cnt <= BIT_LAST;
            if (rx_state == RX_DATA) begin
               rx_shift <= {rx_sync, rx_shift[7:1]};
               rx_bit   <= rx_bit + 3'd1;
            end
         end else begin
            rx_cnt <= rx_cnt - 16'd1;
         end
         rxpend <= rx_done;
         if (rx_done) rxbuf <= rx_shift;
      end
   end

   // ---------------- transmit master ----------------
   always_comb begin
      tx_next  = tx_state;
      tx_start = 1'b0;
      pr_wr    = 1'b0;
      unique case (tx_state)
         TX_IDLE: if (enable && !kb_wr && armrdata[30]) begin
                     tx_next  = TX_SEND;
                     tx_start = 1'b1;
                  end
         TX_SEND: if (tx_tick && tx_bit == 4'd9) tx_next = TX_DONE;
         TX_DONE: if (!kb_wr) begin
                     pr_wr   = 1'b1;
                     tx_next = TX_GAP;
                  end
         TX_GAP:  tx_next = TX_IDLE;
         default: tx_next = TX_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         tx_state <= TX_IDLE;
      end else begin
         tx_state <= tx_next;
      end
   end

   // The shifter back-fills with ones, so after the 8 data bits it presents
   // the stop bit and keeps txd high through DONE and GAP.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         txd      <= 1'b1;
         tx_cnt   <= 16'd0;
         tx_bit   <= 4'd0;
         tx_shift <= 8'hFF;
      end else if (tx_start) begin
         txd      <= 1'b0;
         tx_shift <= armrdata[7:0];
         tx_cnt   <= BIT_LAST;
         tx_bit   <= 4'd0;
      end else if (tx_state == TX_SEND) begin
         if (tx_tick) begin
            txd      <= tx_shift[0];
            tx_shift <= {1'b1, tx_shift[7:1]};
            tx_cnt   <= BIT_LAST;
            tx_bit   <= tx_bit + 4'd1;
         end else begin
            tx_cnt <= tx_cnt - 16'd1;
         end
      end
   end

   // ---------------- sticky flags ----------------
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         kbovrun <= 1'b0;
         frmerr  <= 1'b0;
      end else begin
         if (kb_wr && armrdata[31]) kbovrun <= 1'b1;
         else if (clrerr)           kbovrun <= 1'b0;
         if (rx_ferr)               frmerr  <= 1'b1;
         else if (clrerr)           frmerr  <= 1'b0;
      end
   end

   // ---------------- register port ----------------
   // The keyboard write owns the port; DONE waits (pr_wr excludes kb_wr).
   always_comb begin
      armwrite = kb_wr | pr_wr;
      armraddr = kb_wr ? 2'd1 : 2'd2;
      armwaddr = 2'd0;
      armwdata = 32'h0000_0000;
      if (kb_wr) begin
         armwaddr = 2'd1;
         armwdata = {1'b1, armrdata[30], 18'b0, 4'b0,
                     (MARKPAR != 0) ? 1'b1 : rxbuf[7], rxbuf[6:0]};
      end else if (pr_wr) begin
         armwaddr = 2'd2;
         armwdata = 32'h8000_0000;
      end
   end

endmodule

// File: tb/tb_pdp8ltty_uart.sv
// tb_pdp8ltty_uart -- directed self-checking bench for pdp8ltty_uart.
// A small teletype model answers register reads; its prfull bit clears
// once a reg 2 write has been seen.
module tb_pdp8ltty_uart;

   localparam int N = 8;

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b0;
   logic        enable = 1'b0;
   logic        rxd = 1'b1;
   logic        clrerr = 1'b0;
   logic        txd, armwrite, kbovrun, frmerr;
   logic [1:0]  armraddr, armwaddr;
   logic [31:0] armwdata, armrdata;

   logic [31:0] reg1_val = 32'h0;
   logic [31:0] reg2_val = 32'h0;
   int          pr_base = 0;
   int          pr_wr_cnt = 0;
   int          cyc = 0;
   int          checks = 0;
   int          passed = 0;

   typedef struct {
      int          cyc;
      logic [1:0]  waddr;
      logic [1:0]  raddr;
      logic [31:0] wdata;
   } wr_t;
   wr_t wr_q[$];

   pdp8ltty_uart #(.CLKDIV(N), .MARKPAR(1)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .enable(enable), .rxd(rxd), .txd(txd),
      .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
      .armwdata(armwdata), .armrdata(armrdata), .kbovrun(kbovrun),
      .frmerr(frmerr), .clrerr(clrerr)
   );

   // prfull reads as set only until the next reg 2 write after it was armed.
   assign armrdata = (armraddr == 2'd1) ? reg1_val :
                     (armraddr == 2'd2) ? {reg2_val[31], reg2_val[30] && (pr_wr_cnt == pr_base),
                                           reg2_val[29:0]} : 32'h0;

   always #5 CLOCK = ~CLOCK;
   always @(posedge CLOCK) cyc <= cyc + 1;

   always @(negedge CLOCK) begin
      if (armwrite === 1'b1) begin
         wr_q.push_back('{cyc: cyc, waddr: armwaddr, raddr: armraddr, wdata: armwdata});
         if (armwaddr == 2'd2) pr_wr_cnt <= pr_wr_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop, output int start_cyc);
      @(posedge CLOCK); #1;
      rxd = 1'b0;
      start_cyc = cyc;
      repeat (N) @(posedge CLOCK); #1;
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (N) @(posedge CLOCK); #1;
      end
      rxd = stop;
      repeat (N) @(posedge CLOCK); #1;
      rxd = 1'b1;
   endtask

   task automatic wait_tx_fall(output int k, output logic ok);
      ok = 1'b0;
      k  = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge CLOCK);
         if (txd === 1'b0) begin
            ok = 1'b1;
            k  = cyc;
         end
      end
   endtask

   task automatic wait_writes(input int base, input int n, input int budget);
      for (int i = 0; i < budget && wr_q.size() < base + n; i++) begin
         @(negedge CLOCK); #1;
      end
   endtask

   task automatic arm_print(input logic [31:0] v);
      reg2_val = v;
      pr_base  = pr_wr_cnt;
   endtask

   initial begin
      int          base, k, sc, lows;
      logic        ok;
      logic [9:0]  bits;

      // ---- reset state ----
      #12;
      check("rst_txd",      32'(txd),      32'd1);
      check("rst_armwrite", 32'(armwrite), 32'd0);
      check("rst_armraddr", 32'(armraddr), 32'd2);
      check("rst_armwaddr", 32'(armwaddr), 32'd0);
      check("rst_armwdata", armwdata,      32'h0);
      check("rst_kbovrun",  32'(kbovrun),  32'd0);
      check("rst_frmerr",   32'(frmerr),   32'd0);
      @(negedge CLOCK);
      RESET  = 1'b1;
      enable = 1'b1;
      repeat (4) @(negedge CLOCK);

      // ---- print 0xC1 ----
      base = wr_q.size();
      arm_print(32'h4000_00C1);
      wait_tx_fall(k, ok);
      check("print_start", 32'(ok), 32'd1);
      repeat (N / 2) @(negedge CLOCK);
      bits[0] = txd;
      for (int i = 1; i < 10; i++) begin
         repeat (N) @(negedge CLOCK);
         bits[i] = txd;
      end
      check("print_bits", 32'(bits), 32'(10'b11_1000_0010));
      wait_writes(base, 1, 40);
      check("print_nwr", 32'(wr_q.size() - base), 32'd1);
      if (wr_q.size() > base) begin
         check("print_waddr", 32'(wr_q[base].waddr), 32'd2);
         check("print_wdata", wr_q[base].wdata, 32'h8000_0000);
         check("print_lat",   wr_q[base].cyc - k, 32'(10 * N));
      end
      lows = 0;
      repeat (30) begin
         @(negedge CLOCK);
         if (txd !== 1'b1) lows++;
      end
      check("print_no_repoll", lows, 0);
      check("print_single_wr", 32'(wr_q.size() - base), 32'd1);

      // ---- receive 0x41 ----
      reg1_val = 32'h4000_0000;
      base = wr_q.size();
      send_byte(8'h41, 1'b1, sc);
      wait_writes(base, 1, 10);
      repeat (4) @(negedge CLOCK);
      check("rx_nwr", 32'(wr_q.size() - base), 32'd1);
      if (wr_q.size() > base) begin
         check("rx_waddr", 32'(wr_q[base].waddr), 32'd1);
         check("rx_raddr", 32'(wr_q[base].raddr), 32'd1);
         check("rx_wdata", wr_q[base].wdata, 32'hC000_00C1);
         check("rx_lat",   wr_q[base].cyc - sc, 32'd78);
      end
      check("rx_kbovrun", 32'(kbovrun), 32'd0);

      // ---- overrun ----
      reg1_val = 32'hC000_00C1;
      base = wr_q.size();
      send_byte(8'h5A, 1'b1, sc);
      wait_writes(base, 1, 10);
      repeat (4) @(negedge CLOCK);
      check("ovr_nwr", 32'(wr_q.size() - base), 32'd1);
      if (wr_q.size() > base) check("ovr_wdata", wr_q[base].wdata, 32'hC000_00DA);
      check("ovr_kbovrun", 32'(kbovrun), 32'd1);
      check("ovr_frmerr",  32'(frmerr),  32'd0);

      // ---- framing error ----
      reg1_val = 32'h4000_0000;
      base = wr_q.size();
      send_byte(8'h33, 1'b0, sc);
      repeat (10) @(negedge CLOCK);
      check("ferr_nwr",    32'(wr_q.size() - base), 32'd0);
      check("ferr_frmerr", 32'(frmerr), 32'd1);

      // ---- clrerr ----
      @(posedge CLOCK); #1 clrerr = 1'b1;
      @(posedge CLOCK); #1 clrerr = 1'b0;
      check("clr_kbovrun", 32'(kbovrun), 32'd0);
      check("clr_frmerr",  32'(frmerr),  32'd0);

      // ---- short glitch: start bit high at its centre, silently dropped ----
      base = wr_q.size();
      @(posedge CLOCK); #1 rxd = 1'b0;
      repeat (2) @(posedge CLOCK); #1 rxd = 1'b1;
      repeat (100) @(posedge CLOCK);
      check("glitch_nwr",    32'(wr_q.size() - base), 32'd0);
      check("glitch_frmerr", 32'(frmerr), 32'd0);

      // ---- receive with enable low: byte is discarded ----
      enable = 1'b0;
      base = wr_q.size();
      send_byte(8'h22, 1'b1, sc);
      repeat (10) @(negedge CLOCK);
      enable = 1'b1;
      repeat (10) @(negedge CLOCK);
      check("dis_rx_nwr", 32'(wr_q.size() - base), 32'd0);

      // ---- collision: keyboard write lands in the DONE cycle ----
      reg1_val = 32'h4000_0000;
      base = wr_q.size();
      arm_print(32'h4000_00C1);
      wait_tx_fall(k, ok);
      check("coll_start", 32'(ok), 32'd1);
      @(posedge CLOCK);
      send_byte(8'h41, 1'b1, sc);
      wait_writes(base, 2, 20);
      check("coll_nwr", 32'(wr_q.size() - base), 32'd2);
      if (wr_q.size() >= base + 2) begin
         check("coll_first_waddr",  32'(wr_q[base].waddr),   32'd1);
         check("coll_first_cyc",    wr_q[base].cyc - k,      32'(10 * N));
         check("coll_first_wdata",  wr_q[base].wdata,        32'hC000_00C1);
         check("coll_second_waddr", 32'(wr_q[base+1].waddr), 32'd2);
         check("coll_second_cyc",   wr_q[base+1].cyc - k,    32'(10 * N + 1));
         check("coll_second_wdata", wr_q[base+1].wdata,      32'h8000_0000);
      end
      repeat (10) @(negedge CLOCK);

      // ---- drop enable during SEND ----
      base = wr_q.size();
      arm_print(32'h4000_00C1);
      wait_tx_fall(k, ok);
      check("dis_start", 32'(ok), 32'd1);
      repeat (20) @(negedge CLOCK);
      enable = 1'b0;
      wait_writes(base, 1, 100);
      check("dis_nwr", 32'(wr_q.size() - base), 32'd1);
      if (wr_q.size() > base) begin
         check("dis_waddr", 32'(wr_q[base].waddr), 32'd2);
         check("dis_lat",   wr_q[base].cyc - k,     32'(10 * N));
      end
      arm_print(32'h4000_00C1);
      lows = 0;
      repeat (40) begin
         @(negedge CLOCK);
         if (txd !== 1'b1) lows++;
      end
      check("dis_no_poll", lows, 0);
      check("dis_no_wr",   32'(wr_q.size() - base), 32'd1);

      // ---- asynchronous reset mid-bit ----
      enable = 1'b1;
      wait_tx_fall(k, ok);
      check("rst_mid_start", 32'(ok), 32'd1);
      repeat (2) @(negedge CLOCK);
      check("rst_mid_pre_txd", 32'(txd), 32'd0);
      #2 RESET = 1'b0;
      #1;
      check("rst_mid_txd",      32'(txd),      32'd1);
      check("rst_mid_armwrite", 32'(armwrite), 32'd0);
      check("rst_mid_armraddr", 32'(armraddr), 32'd2);
      @(negedge CLOCK);
      RESET = 1'b1;
      repeat (2) @(negedge CLOCK);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
